hid_multi: RTL and testbench
============================

// Module: hid_multi
// PURPOSE
//  Next-generation MCU-facing HID endpoint: decodes the MCU byte-stream protocol (strobe/start/data)
//  into a buffered keyboard byte stream, N joystick registers, a quadrature mouse and a DB9 change IRQ.
//  Sits between the IO-MCU SPI byte engine and the machine core; keycode translation happens downstream.
//  Adds over the previous HID block: keyboard FIFO with valid/ready, saturating mouse counters,
//  a runtime-programmable mouse step rate, and a parametrised joystick count.
// PARAMETERS
//  NUM_JOY        2     number of joystick registers (1..8)
//  JOY_W          8     bits per joystick register
//  KBD_DEPTH      8     keyboard FIFO entries (power of 2, 2..8)
//  MCNT_W         10    signed mouse accumulator width (8..16)
//  MDIV_DEFAULT   8191  reset value of the mouse step period in clk cycles
// PORTS
//  clk            in   1            system clock
//  reset_n        in   1            asynchronous active-low reset
//  data_in_strobe in   1            one-cycle pulse: data_in valid
//  data_in_start  in   1            qualifies the strobe: data_in is a command byte
//  data_in        in   8            MCU byte
//  data_out       out  8            reply byte, updated on each non-start strobe
//  db9_port       in   6            async local joystick lines
//  irq            out  1            level interrupt to MCU
//  iack           in   1            interrupt acknowledge pulse
//  kbd_valid      out  1            FIFO head valid
//  kbd_ready      in   1            consumer accepts head this cycle
//  kbd_data       out  8            FIFO head, raw MCU code (bit7 = release)
//  mouse          out  5            {~btn, x[1:0], y[1:0]} quadrature
//  joystick       out  NUM_JOY*JOY_W  joystick n at [n*JOY_W +: JOY_W]
// BEHAVIOUR
//  Reset: all outputs 0, except mouse = 5'b10000 (button released); FIFO empty, overflow=0,
//   irq_en=0, period=MDIV_DEFAULT, accumulators 0.
//  Protocol: a start strobe latches cmd, idx<=0; each later strobe handles byte idx, then idx++ (saturates at 15).
//   The reply for byte idx is registered one clk after its strobe.
//  CMD0 status: idx0 -> 8'h02 (version); idx1 -> NUM_JOY; idx2 -> {ovf, 3'b0, count[3:0]}; reading idx2 clears ovf.
//  CMD1 key: idx0 pushes data_in. If the FIFO is full and no pop occurs this cycle -> byte dropped, ovf<=1.
//   Push and pop in the same cycle on a full FIFO -> both take effect.
//   kbd_valid = !empty; pop when kbd_valid && kbd_ready; kbd_data stable while kbd_valid && !kbd_ready.
//  CMD2 mouse: idx0 btn<=data_in[0]; idx1/idx2 add sign-extended data_in to x/y accumulators,
//   saturating at +/-(2^(MCNT_W-1)-1).
//  CMD3 joystick: idx0 dev<=data_in; idx1 joystick[dev]<=data_in[JOY_W-1:0] if dev<NUM_JOY, else ignored.
//  CMD4 db9 read: every byte returns {2'b00, db9_sync}; idx0 sets irq_en.
//  CMD5 mouse period: idx0 -> hi byte staged; idx1 -> period<={hi, data_in}, loaded at once; 0 is treated as 1.
//  Unknown cmd: bytes ignored, data_out holds its value.
//  Mouse tick: free-running divider, independent of strobes. Tick when divider >= period-1; divider then clears.
//   On a tick, each axis with a nonzero accumulator steps the 2-bit Gray code one phase toward zero and moves
//   the accumulator 1 toward zero.
//   x negative: x<={~x[0], x[1]}; x positive: x<={x[0], ~x[1]}; y uses the opposite mapping.
//   A same-cycle add and step combine: acc + data -/+ 1, then saturate.
//  IRQ: db9_port passes a 2-flop synchroniser plus one delay stage. While irq_en, any change sets irq=1, irq_en=0.
//   Set beats iack in the same cycle; otherwise iack clears irq.
//  Async reset mid-transfer aborts the transfer; the next byte must be a start.
// STRUCTURE
//  hid_pkg: CMD_STATUS..CMD_MPERIOD localparams, HID_VERSION=8'h02, mouse reset constant.
//  Sub-module hid_fifo (DEPTH, W=8; push/pop/full/empty/count; no overflow logic inside).
//  Top holds the protocol decoder, mouse, joystick and IRQ logic.
// TESTING
//  1 CMD0 read of 3 bytes -> 02, NUM_JOY, 00; after 9 key pushes with ready=0 (depth 8) -> idx2 returns 8'h88, next read 8'h08.
//  2 Push 3A,BA with kbd_ready held 0 -> kbd_data=3A stable; raise ready 2 clk -> 3A then BA popped, kbd_valid=0.
//  3 CMD5 00,04 then CMD2 01,03,FD -> btn out=0; exactly 3 x steps and 3 y steps, 4 clk apart; accumulators 0.
//  4 MCNT_W=8: four CMD2 bytes x=7F -> accumulator saturates at 127; no wrap to negative.
//  5 CMD3 01,55 -> joystick[15:8]=55; CMD3 05,AA with NUM_JOY=2 -> no change.
//  6 CMD4 then toggle db9_port[2] -> irq within 4 clk; second toggle before CMD4 -> no new irq; iack clears irq.

Source files
------------

// File: rtl/hid_pkg.sv
// hid_pkg -- shared constants for the MCU-facing HID endpoint.
//   CMD_*        command byte values carried by a start strobe
//   HID_VERSION  value returned by the status command, byte 0
//   MOUSE_RESET  mouse output after reset: button released, both phases 00
package hid_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_KEY     = 8'd1;
  localparam logic [7:0] CMD_MOUSE   = 8'd2;
  localparam logic [7:0] CMD_JOY     = 8'd3;
  localparam logic [7:0] CMD_DB9     = 8'd4;
  localparam logic [7:0] CMD_MPERIOD = 8'd5;

  localparam logic [7:0] HID_VERSION = 8'h02;
  localparam logic [4:0] MOUSE_RESET = 5'b10000;

endpackage

// File: rtl/hid_multi_if.sv
// hid_multi_if -- MCU byte stream plus keyboard valid/ready stream.
//   data_in_strobe/data_in_start/data_in : byte from the MCU SPI engine
//   data_out                             : reply byte back to the MCU
//   kbd_valid/kbd_ready/kbd_data         : keyboard FIFO head to the machine core
// Modport master is the MCU/core side, slave is the HID endpoint.
interface hid_multi_if;

  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       kbd_valid;
  logic       kbd_ready;
  logic [7:0] kbd_data;

  modport master (
    output data_in_strobe, data_in_start, data_in, kbd_ready,
    input  data_out, kbd_valid, kbd_data
  );

  modport slave (
    input  data_in_strobe, data_in_start, data_in, kbd_ready,
    output data_out, kbd_valid, kbd_data
  );

endinterface

// File: rtl/hid_fifo.sv
// hid_fifo -- small synchronous FIFO (power-of-two depth).
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, wdata_i     write request and data (ignored when full unless popping)
//   pop_i, rdata_o      read request and head data (ignored when empty)
//   full_o, empty_o     status flags
//   count_o             number of stored entries
module hid_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A pop frees the slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/hid_multi.sv
// hid_multi -- MCU-facing HID endpoint.
//   clk, reset_n   clock, asynchronous active-low reset
//   bus            hid_multi_if.slave: MCU byte stream in, reply byte out,
//                  keyboard FIFO head out with valid/ready
//   db9_port       asynchronous local joystick lines
//   irq, iack      level interrupt to the MCU and its acknowledge pulse
//   mouse          {~button, x phase[1:0], y phase[1:0]} quadrature
//   joystick       NUM_JOY registers, register n at [n*JOY_W +: JOY_W]
module hid_multi
  import hid_pkg::*;
#(
  parameter int NUM_JOY      = 2,
  parameter int JOY_W        = 8,
  parameter int KBD_DEPTH    = 8,
  parameter int MCNT_W       = 10,
  parameter int MDIV_DEFAULT = 8191
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hid_multi_if.slave               bus,
  input  logic [5:0]               db9_port,
  output logic                     irq,
  input  logic                     iack,
  output logic [4:0]               mouse,
  output logic [NUM_JOY*JOY_W-1:0] joystick
);

  localparam int CW = $clog2(KBD_DEPTH) + 1;
  localparam int SW = MCNT_W + 2;  // headroom for acc + byte - step before saturation
  localparam logic signed [SW-1:0] ACC_MAX = SW'((1 << (MCNT_W-1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;

  function automatic logic signed [MCNT_W-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v > ACC_MAX) return ACC_MAX[MCNT_W-1:0];
    if (v < ACC_MIN) return ACC_MIN[MCNT_W-1:0];
    return v[MCNT_W-1:0];
  endfunction

  // up: 00->01->11->10 ; down: the reverse walk
  function automatic logic [1:0] gray_step(input logic [1:0] g, input logic up);
    return up ? {g[0], ~g[1]} : {~g[0], g[1]};
  endfunction

  // Protocol state
  logic [7:0] cmd_q, data_out_q, reply_d, dev_q, hi_q;
  logic [3:0] idx_q;
  logic       act_q, ovf_q;

  // Keyboard FIFO
  logic          kbd_push, kbd_pop, kbd_full, kbd_empty;
  logic [7:0]    kbd_head;
  logic [CW-1:0] kbd_cnt;
  logic [3:0]    cnt4;

  // Mouse
  logic                     btn_q, tick;
  logic [1:0]               xq_q, yq_q;
  logic signed [MCNT_W-1:0] xacc_q, yacc_q;
  logic signed [SW-1:0]     din_s, x_add, y_add, x_stp, y_stp, x_sum, y_sum;
  logic [15:0]              period_q, div_q, period_eff;
  logic                     x_move, y_move;

  // Joystick and DB9
  logic [NUM_JOY*JOY_W-1:0] joy_q;
  logic [5:0]               db9_s1_q, db9_s2_q, db9_d_q;
  logic                     db9_chg, irq_en_q, irq_q;

  // Decoded byte strobes; non-start bytes count only inside a started transfer.
  logic byte_stb, stb_key0, stb_st2, stb_m0, stb_m1, stb_m2;
  logic stb_j0, stb_j1, stb_d0, stb_p0, stb_p1;

  assign byte_stb = bus.data_in_strobe && !bus.data_in_start && act_q;
  assign stb_st2  = byte_stb && cmd_q == CMD_STATUS  && idx_q == 4'd2;
  assign stb_key0 = byte_stb && cmd_q == CMD_KEY     && idx_q == 4'd0;
  assign stb_m0   = byte_stb && cmd_q == CMD_MOUSE   && idx_q == 4'd0;
  assign stb_m1   = byte_stb && cmd_q == CMD_MOUSE   && idx_q == 4'd1;
  assign stb_m2   = byte_stb && cmd_q == CMD_MOUSE   && idx_q == 4'd2;
  assign stb_j0   = byte_stb && cmd_q == CMD_JOY     && idx_q == 4'd0;
  assign stb_j1   = byte_stb && cmd_q == CMD_JOY     && idx_q == 4'd1;
  assign stb_d0   = byte_stb && cmd_q == CMD_DB9     && idx_q == 4'd0;
  assign stb_p0   = byte_stb && cmd_q == CMD_MPERIOD && idx_q == 4'd0;
  assign stb_p1   = byte_stb && cmd_q == CMD_MPERIOD && idx_q == 4'd1;

  hid_fifo #(.DEPTH(KBD_DEPTH), .W(8)) u_kbd_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (kbd_push),
    .pop_i   (kbd_pop),
    .wdata_i (bus.data_in),
    .rdata_o (kbd_head),
    .full_o  (kbd_full),
    .empty_o (kbd_empty),
    .count_o (kbd_cnt)
  );

  assign kbd_push      = stb_key0;
  assign kbd_pop       = !kbd_empty && bus.kbd_ready;
  assign bus.kbd_valid = !kbd_empty;
  assign bus.kbd_data  = kbd_empty ? 8'h00 : kbd_head;
  assign bus.data_out  = data_out_q;
  assign cnt4          = 4'(kbd_cnt);

  always_comb begin
    reply_d = data_out_q;
    if (byte_stb) begin
      case (cmd_q)
        CMD_STATUS: begin
          case (idx_q)
            4'd0:    reply_d = HID_VERSION;
            4'd1:    reply_d = 8'(NUM_JOY);
            4'd2:    reply_d = {ovf_q, 3'b000, cnt4};
            default: reply_d = 8'h00;
          endcase
        end
        CMD_DB9:                                   reply_d = {2'b00, db9_s2_q};
        CMD_KEY, CMD_MOUSE, CMD_JOY, CMD_MPERIOD:  reply_d = 8'h00;
        default:                                   reply_d = data_out_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q      <= '0;
      idx_q      <= '0;
      act_q      <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (bus.data_in_strobe && bus.data_in_start) begin
        cmd_q <= bus.data_in;
        idx_q <= '0;
        act_q <= 1'b1;
      end else if (byte_stb && idx_q != 4'd15) begin
        idx_q <= idx_q + 4'd1;
      end
      data_out_q <= reply_d;
      if (kbd_push && kbd_full && !kbd_pop) ovf_q <= 1'b1;
      else if (stb_st2)                     ovf_q <= 1'b0;
    end
  end

  // Mouse: free-running divider and accumulator stepping toward zero
  assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
  assign tick       = div_q >= period_eff - 16'd1;
  assign din_s      = SW'($signed(bus.data_in));
  assign x_add      = stb_m1 ? din_s : '0;
  assign y_add      = stb_m2 ? din_s : '0;
  assign x_move     = tick && xacc_q != '0;
  assign y_move     = tick && yacc_q != '0;
  assign x_stp      = !x_move ? '0 : (xacc_q[MCNT_W-1] ? '1 : SW'(1));
  assign y_stp      = !y_move ? '0 : (yacc_q[MCNT_W-1] ? '1 : SW'(1));
  assign x_sum      = SW'(xacc_q) + x_add - x_stp;
  assign y_sum      = SW'(yacc_q) + y_add - y_stp;
  assign mouse      = {~btn_q, xq_q, yq_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q    <= ~MOUSE_RESET[4];
      xq_q     <= MOUSE_RESET[3:2];
      yq_q     <= MOUSE_RESET[1:0];
      xacc_q   <= '0;
      yacc_q   <= '0;
      div_q    <= '0;
      hi_q     <= '0;
      period_q <= 16'(MDIV_DEFAULT);
    end else begin
      div_q  <= tick ? 16'd0 : div_q + 16'd1;
      xacc_q <= sat_acc(x_sum);
      yacc_q <= sat_acc(y_sum);
      // y walks the opposite Gray direction from x for the same sign
      if (x_move) xq_q <= gray_step(xq_q, !xacc_q[MCNT_W-1]);
      if (y_move) yq_q <= gray_step(yq_q, yacc_q[MCNT_W-1]);
      if (stb_m0) btn_q    <= bus.data_in[0];
      if (stb_p0) hi_q     <= bus.data_in;
      if (stb_p1) period_q <= {hi_q, bus.data_in};
    end
  end

  // Joystick registers; out-of-range device numbers fall through the loop untouched
  assign joystick = joy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dev_q <= '0;
      joy_q <= '0;
    end else begin
      if (stb_j0) dev_q <= bus.data_in;
      if (stb_j1) begin
        for (int n = 0; n < NUM_JOY; n++) begin
          if (dev_q == 8'(n)) joy_q[n*JOY_W +: JOY_W] <= bus.data_in[JOY_W-1:0];
        end
      end
    end
  end

  // DB9 change interrupt: two-flop synchroniser plus one compare stage
  assign db9_chg = db9_s2_q != db9_d_q;
  assign irq     = irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db9_s1_q <= '0;
      db9_s2_q <= '0;
      db9_d_q  <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      db9_s1_q <= db9_port;
      db9_s2_q <= db9_s1_q;
      db9_d_q  <= db9_s2_q;
      // A change consumes the arm and wins over a same-cycle acknowledge
      if (irq_en_q && db9_chg) begin
        irq_q    <= 1'b1;
        irq_en_q <= 1'b0;
      end else begin
        if (stb_d0) irq_en_q <= 1'b1;
        if (iack)   irq_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hid_multi.sv
module tb_hid_multi;

  localparam int NUM_JOY   = 2;
  localparam int JOY_W     = 8;
  localparam int KBD_DEPTH = 8;
  localparam int MCNT_W    = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  hid_multi_if bus();
  logic [5:0]  db9_port;
  logic        irq, iack;
  logic [4:0]  mouse;
  logic [NUM_JOY*JOY_W-1:0] joystick;

  hid_multi #(.NUM_JOY(NUM_JOY), .JOY_W(JOY_W), .KBD_DEPTH(KBD_DEPTH),
              .MCNT_W(MCNT_W), .MDIV_DEFAULT(8191)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .db9_port(db9_port),
    .irq(irq), .iack(iack), .mouse(mouse), .joystick(joystick)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mouse step observer
  logic [1:0] px = 2'b00, py = 2'b00;
  int xsteps = 0, ysteps = 0;
  int xt[$], yt[$];
  always @(negedge clk) begin
    if (mouse[3:2] !== px) begin xsteps <= xsteps + 1; xt.push_back(cyc); end
    if (mouse[1:0] !== py) begin ysteps <= ysteps + 1; yt.push_back(cyc); end
    px <= mouse[3:2];
    py <= mouse[1:0];
  end

  // Reference state
  logic [7:0] kq[$];
  logic       m_ovf = 1'b0;
  logic [JOY_W-1:0] m_joy [NUM_JOY];

  function automatic int ph(input logic [1:0] g);
    case (g)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int mod4(input int v);
    return ((v % 4) + 4) % 4;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic send(input logic st, input logic [7:0] b);
    @(negedge clk);
    bus.data_in_strobe = 1'b1;
    bus.data_in_start  = st;
    bus.data_in        = b;
    @(negedge clk);
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
  endtask

  task automatic push_key(input logic [7:0] b);
    send(1'b1, 8'd1);
    send(1'b0, b);
    if (kq.size() < KBD_DEPTH) kq.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic read_count(input string nm);
    logic [7:0] exp_v;
    send(1'b1, 8'd0);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    exp_v = {m_ovf, 3'b000, 4'(kq.size())};
    send(1'b0, 8'h00);
    m_ovf = 1'b0;
    n_chk++;
    if (bus.data_out !== exp_v) begin
      n_fail++; $display("FAIL %s: got %h want %h", nm, bus.data_out, exp_v);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = kq.size();
    bus.kbd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = kq.pop_front();
      n_chk++;
      if (bus.kbd_valid !== 1'b1 || bus.kbd_data !== e) begin
        n_fail++; $display("FAIL %s[%0d]: got v=%b d=%h want v=1 d=%h", nm, i, bus.kbd_valid, bus.kbd_data, e);
      end
      @(negedge clk);
    end
    bus.kbd_ready = 1'b0;
    n_chk++;
    if (bus.kbd_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_empty: got valid %b want 0", nm, bus.kbd_valid);
    end
  endtask

  task automatic test_reset;
    n_chk++;
    if (bus.data_out !== 8'h00 || irq !== 1'b0 || bus.kbd_valid !== 1'b0 || bus.kbd_data !== 8'h00 ||
        mouse !== 5'b10000 || joystick !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got do=%h irq=%b kv=%b kd=%h m=%b j=%h want 00 0 0 00 10000 0",
               bus.data_out, irq, bus.kbd_valid, bus.kbd_data, mouse, joystick);
    end
  endtask

  task automatic test_reset_abort;
    send(1'b1, 8'd0);
    send(1'b0, 8'h00);
    n_chk++;
    if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL abort_pre: got %h want 02", bus.data_out); end
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    n_chk++;
    if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL abort_reset: got %h want 00", bus.data_out); end
    send(1'b0, 8'h00);
    n_chk++;
    if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL abort_nostart: got %h want 00", bus.data_out); end
    send(1'b1, 8'd0);
    send(1'b0, 8'h00);
    n_chk++;
    if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL abort_restart: got %h want 02", bus.data_out); end
  endtask

  task automatic test_status;
    logic [7:0] want [3];
    want[0] = 8'h02; want[1] = 8'(NUM_JOY); want[2] = 8'h00;
    send(1'b1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'h00);
      n_chk++;
      if (bus.data_out !== want[i]) begin
        n_fail++; $display("FAIL status_byte%0d: got %h want %h", i, bus.data_out, want[i]);
      end
    end
    for (int i = 0; i < KBD_DEPTH + 1; i++) push_key(8'($urandom));
    read_count("status_overflow");
    read_count("status_after_clear");
    drain("overflow_drain");
  endtask

  task automatic test_full_push_pop;
    logic [7:0] b;
    for (int i = 0; i < KBD_DEPTH; i++) push_key(8'($urandom));
    b = 8'($urandom);
    @(negedge clk);
    bus.data_in_strobe = 1'b1; bus.data_in_start = 1'b1; bus.data_in = 8'd1;
    @(negedge clk);
    bus.data_in_start = 1'b0; bus.data_in = b; bus.kbd_ready = 1'b1;
    @(negedge clk);
    bus.data_in_strobe = 1'b0; bus.kbd_ready = 1'b0;
    void'(kq.pop_front());
    kq.push_back(b);
    read_count("full_push_pop_count");
    drain("full_push_pop_drain");
  endtask

  task automatic test_kbd_stream;
    push_key(8'h3A);
    push_key(8'hBA);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if (bus.kbd_valid !== 1'b1 || bus.kbd_data !== 8'h3A) begin
        n_fail++; $display("FAIL kbd_stall%0d: got v=%b d=%h want v=1 d=3a", i, bus.kbd_valid, bus.kbd_data);
      end
    end
    drain("kbd_stream");
  endtask

  task automatic test_mouse_spec;
    int bx, by, bxi, byi, p0x, p0y;
    send(1'b1, 8'd5); send(1'b0, 8'h00); send(1'b0, 8'h04);
    bx = xsteps; by = ysteps; bxi = xt.size(); byi = yt.size();
    p0x = ph(mouse[3:2]); p0y = ph(mouse[1:0]);
    send(1'b1, 8'd2); send(1'b0, 8'h01);
    n_chk++;
    if (mouse[4] !== 1'b0) begin n_fail++; $display("FAIL mouse_btn: got %b want 0", mouse[4]); end
    send(1'b0, 8'h03); send(1'b0, 8'hFD);
    repeat (40) @(negedge clk);
    n_chk++;
    if (xsteps - bx != 3 || ysteps - by != 3) begin
      n_fail++; $display("FAIL mouse_steps: got x=%0d y=%0d want 3 3", xsteps - bx, ysteps - by);
    end
    n_chk++;
    if (xt.size() < bxi + 3 || yt.size() < byi + 3) begin
      n_fail++; $display("FAIL mouse_spacing: got too few steps want 3");
    end else if (xt[bxi+1] - xt[bxi] != 4 || xt[bxi+2] - xt[bxi+1] != 4 ||
                 yt[byi+1] - yt[byi] != 4 || yt[byi+2] - yt[byi+1] != 4) begin
      n_fail++; $display("FAIL mouse_spacing: got x %0d,%0d y %0d,%0d want 4",
                         xt[bxi+1] - xt[bxi], xt[bxi+2] - xt[bxi+1], yt[byi+1] - yt[byi], yt[byi+2] - yt[byi+1]);
    end
    n_chk++;
    if (ph(mouse[3:2]) != mod4(p0x + 3) || ph(mouse[1:0]) != mod4(p0y + 3)) begin
      n_fail++; $display("FAIL mouse_phase: got x=%b y=%b want phases %0d %0d",
                         mouse[3:2], mouse[1:0], mod4(p0x + 3), mod4(p0y + 3));
    end
  endtask

  task automatic test_mouse_sat;
    int bx, p0x;
    send(1'b1, 8'd5); send(1'b0, 8'hFF); send(1'b0, 8'hFF);
    bx = xsteps; p0x = ph(mouse[3:2]);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'd2); send(1'b0, 8'h00); send(1'b0, 8'h7F);
    end
    send(1'b1, 8'd5); send(1'b0, 8'h00); send(1'b0, 8'h01);
    repeat (300) @(negedge clk);
    n_chk++;
    if (xsteps - bx != (1 << (MCNT_W-1)) - 1) begin
      n_fail++; $display("FAIL mouse_sat_steps: got %0d want %0d", xsteps - bx, (1 << (MCNT_W-1)) - 1);
    end
    n_chk++;
    if (ph(mouse[3:2]) != mod4(p0x + 127) || mouse[4] !== 1'b1) begin
      n_fail++; $display("FAIL mouse_sat_phase: got %b want phase %0d btn out 1", mouse, mod4(p0x + 127));
    end
  endtask

  task automatic test_mouse_random;
    send(1'b1, 8'd5); send(1'b0, 8'h00); send(1'b0, 8'h02);
    for (int k = 0; k < 3; k++) begin
      int rx, ry, bx, by, p0x, p0y;
      logic btn;
      rx = int'($urandom_range(60)) - 30;
      ry = int'($urandom_range(60)) - 30;
      btn = 1'($urandom_range(1));
      bx = xsteps; by = ysteps; p0x = ph(mouse[3:2]); p0y = ph(mouse[1:0]);
      send(1'b1, 8'd2); send(1'b0, {7'd0, btn}); send(1'b0, 8'(rx)); send(1'b0, 8'(ry));
      repeat (100) @(negedge clk);
      n_chk++;
      if (xsteps - bx != iabs(rx) || ysteps - by != iabs(ry) || mouse[4] !== ~btn ||
          ph(mouse[3:2]) != mod4(p0x + rx) || ph(mouse[1:0]) != mod4(p0y - ry)) begin
        n_fail++;
        $display("FAIL mouse_rand%0d: got steps %0d/%0d mouse %b want %0d/%0d btn %b phases %0d %0d",
                 k, xsteps - bx, ysteps - by, mouse, iabs(rx), iabs(ry), ~btn, mod4(p0x + rx), mod4(p0y - ry));
      end
    end
  endtask

  task automatic joy_write(input logic [7:0] dev, input logic [7:0] val, input string nm);
    logic [NUM_JOY*JOY_W-1:0] e;
    send(1'b1, 8'd3); send(1'b0, dev); send(1'b0, val);
    if (dev < NUM_JOY) m_joy[dev] = val[JOY_W-1:0];
    for (int n = 0; n < NUM_JOY; n++) e[n*JOY_W +: JOY_W] = m_joy[n];
    n_chk++;
    if (joystick !== e) begin n_fail++; $display("FAIL %s: got %h want %h", nm, joystick, e); end
  endtask

  task automatic test_joystick;
    for (int n = 0; n < NUM_JOY; n++) m_joy[n] = '0;
    joy_write(8'd1, 8'h55, "joy_dev1");
    joy_write(8'd5, 8'hAA, "joy_dev5_ignored");
    for (int i = 0; i < 4; i++) joy_write(8'($urandom_range(3)), 8'($urandom), "joy_rand");
  endtask

  task automatic test_irq;
    logic seen;
    db9_port = 6'($urandom);
    repeat (5) @(negedge clk);
    send(1'b1, 8'd4); send(1'b0, 8'h00);
    n_chk++;
    if (bus.data_out !== {2'b00, db9_port} || irq !== 1'b0) begin
      n_fail++; $display("FAIL db9_read: got %h irq %b want %h irq 0", bus.data_out, irq, {2'b00, db9_port});
    end
    db9_port[2] = ~db9_port[2];
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL irq_set: got irq %b want 1 within 4 clk", irq); end
    iack = 1'b1; @(negedge clk); iack = 1'b0;
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_iack: got %b want 0", irq); end
    db9_port[2] = ~db9_port[2];
    repeat (6) @(negedge clk);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disarmed: got %b want 0", irq); end
    send(1'b1, 8'd4); send(1'b0, 8'h00);
    iack = 1'b1;
    db9_port[0] = ~db9_port[0];
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
    end
    iack = 1'b0;
    n_chk++;
    if (!seen || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_set_beats_iack: got seen=%b irq=%b want seen=1 irq=0", seen, irq);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
    bus.data_in        = 8'h00;
    bus.kbd_ready      = 1'b0;
    db9_port           = 6'd0;
    iack               = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_reset_abort;
    test_status;
    test_full_push_pop;
    test_kbd_stream;
    test_mouse_spec;
    test_mouse_sat;
    test_mouse_random;
    test_joystick;
    test_irq;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
